// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: per-channel servo angle targets set from a debounced
// 4-bit switch code or a host write port, with each angle slewing toward
// its target at a fixed rate.
// Build option: define ANGLE_RAMP_EN to enable the tick-paced ramp. Without
// it, each angle follows its target one clock after the target changes.
module servo_angle_ramp #(
  parameter int N_CH      = 4,
  parameter int ANGLE_W   = 8,
  parameter int MAX_ANGLE = 180,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 50000,
  parameter int DB_CYCLES = 1000,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                sw,
  input  logic [CH_W-1:0]           sw_ch,
  input  logic                      tgt_valid,
  output logic                      tgt_ready,
  input  logic [CH_W-1:0]           tgt_ch,
  input  logic [ANGLE_W-1:0]        tgt_angle,
  output logic [N_CH*ANGLE_W-1:0]   angle,
  output logic [N_CH-1:0]           busy
);

  localparam logic [ANGLE_W-1:0] MAX_A  = ANGLE_W'(MAX_ANGLE);
  localparam logic [ANGLE_W-1:0] HALF_A = ANGLE_W'(MAX_ANGLE / 2);
  localparam int                 DBW    = $clog2(DB_CYCLES + 1);

  if (N_CH < 1 || N_CH > 16 || TICK_DIV < 1 || DB_CYCLES < 1 || STEP < 1 ||
      MAX_ANGLE >= (1 << ANGLE_W)) begin : g_cfg_check
    $error("servo_angle_ramp: illegal parameter set");
  end

  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    return (a > MAX_A) ? MAX_A : a;
  endfunction

  logic [3:0]         sync_p0, sync_p1;
  logic [3:0]         db_cand, db_stable;
  logic [DBW-1:0]     db_cnt;
  logic               db_accept;
  logic               sw_map;
  logic [ANGLE_W-1:0] sw_angle;
  logic               commit;
  logic               rdy_q;
  logic               host_we;
  logic [ANGLE_W-1:0] host_val;
  logic [ANGLE_W-1:0] tgt_q [N_CH];
  logic [ANGLE_W-1:0] ang_q [N_CH];

  // ---- stage p0/p1: switch synchroniser, then debounce on sync_p1 ----
  // Synchronise the raw switch code and track how long it has been unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0   <= 4'b0000;
      sync_p1   <= 4'b0000;
      db_cand   <= 4'b0000;
      db_stable <= 4'b0000;
      db_cnt    <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
      if (sync_p1 != db_cand) begin
        db_cand <= sync_p1;
        db_cnt  <= '0;
      end else if (db_cnt != DBW'(DB_CYCLES)) begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (db_accept) db_stable <= db_cand;
    end
  end

  // A code is accepted once, on its last required stable cycle, only if new.
  assign db_accept = (sync_p1 == db_cand) && (db_cnt == DBW'(DB_CYCLES - 1)) &&
                     (db_cand != db_stable);

  // Decode the accepted switch code; unmapped codes commit nothing.
  always_comb begin
    sw_map   = 1'b0;
    sw_angle = '0;
    case (db_cand)
      4'b0000: begin sw_map = 1'b1; sw_angle = '0;     end
      4'b1111: begin sw_map = 1'b1; sw_angle = MAX_A;  end
      4'b1100: begin sw_map = 1'b1; sw_angle = HALF_A; end
      default: begin sw_map = 1'b0; sw_angle = '0;     end
    endcase
    commit = db_accept && sw_map;
  end

  // Host port is always ready once out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  assign tgt_ready = rdy_q;
  assign host_we   = tgt_valid && rdy_q;
  assign host_val  = clamp_angle(tgt_angle);

  // ---- stage p2: target update (host beats switch on the same channel) ----
  // Out-of-range channel indices match no entry and are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) tgt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (host_we && int'(tgt_ch) == i)     tgt_q[i] <= host_val;
        else if (commit && int'(sw_ch) == i)  tgt_q[i] <= sw_angle;
      end
    end
  end

`ifdef ANGLE_RAMP_EN
  localparam int                 TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [ANGLE_W:0]   STEP_X = (ANGLE_W + 1)'(STEP);

  // One step toward the target, computed one bit wider and clamped at it.
  function automatic logic [ANGLE_W-1:0] ramp_step(input logic [ANGLE_W-1:0] cur,
                                                   input logic [ANGLE_W-1:0] tgt);
    logic [ANGLE_W:0] c, t, diff, nxt;
    c    = {1'b0, cur};
    t    = {1'b0, tgt};
    diff = '0;
    nxt  = c;
    if (c < t) begin
      diff = t - c;
      nxt  = (diff > STEP_X) ? c + STEP_X : t;
    end else if (c > t) begin
      diff = c - t;
      nxt  = (diff > STEP_X) ? c - STEP_X : t;
    end
    return nxt[ANGLE_W-1:0];
  endfunction

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  // Free-running ramp tick divider; target writes never restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // ---- stage p3: angle slews one step per tick ----
  // Move every channel one step toward its target on each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) ang_q[i] <= '0;
    end else if (tick) begin
      for (int i = 0; i < N_CH; i++) ang_q[i] <= ramp_step(ang_q[i], tgt_q[i]);
    end
  end
`else
  // ---- stage p3: angle follows target ----
  // Without ramping, each angle copies its target one clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) ang_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) ang_q[i] <= tgt_q[i];
    end
  end
`endif

  // Pack angles and flag channels still moving toward their target.
  always_comb begin
    angle = '0;
    busy  = '0;
    for (int i = 0; i < N_CH; i++) begin
      angle[i*ANGLE_W +: ANGLE_W] = ang_q[i];
      busy[i]                     = (ang_q[i] != tgt_q[i]);
    end
  end

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Self-checking bench for servo_angle_ramp (N_CH=4, TICK_DIV=4, DB_CYCLES=3).
// Follows the ANGLE_RAMP_EN build option of the design.
module tb_servo_angle_ramp;
  localparam int N_CH = 4;
  localparam int AW   = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       sw = 4'b0000;
  logic [1:0]       sw_ch = 2'd0;
  logic             tgt_valid = 1'b0;
  logic             tgt_ready;
  logic [1:0]       tgt_ch = 2'd0;
  logic [AW-1:0]    tgt_angle = '0;
  logic [N_CH*AW-1:0] angle;
  logic [N_CH-1:0]  busy;

  servo_angle_ramp #(
    .N_CH(4), .ANGLE_W(8), .MAX_ANGLE(180), .STEP(1), .TICK_DIV(4), .DB_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .sw(sw), .sw_ch(sw_ch),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_ch(tgt_ch),
    .tgt_angle(tgt_angle), .angle(angle), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct { int ch; int exp; } sb_t;
  typedef struct { int ch; int val; int exp; } vec_t;
  sb_t sbq[$];

  function automatic int ang(input int ch);
    return int'(angle[ch*AW +: AW]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input int ch, input int val);
    tgt_valid = 1'b1;
    tgt_ch    = ch[1:0];
    tgt_angle = val[7:0];
    cyc(1);
    tgt_valid = 1'b0;
  endtask

  task automatic wait_idle(input int ch);
    for (int k = 0; k < 2000 && busy[ch]; k++) cyc(1);
    check($sformatf("settle_ch%0d", ch), int'(busy[ch]), 0);
  endtask

  task automatic sb_push(input int ch, input int exp);
    sb_t e;
    e.ch  = ch;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input string name);
    sb_t e;
    e = sbq.pop_front();
    check(name, ang(e.ch), e.exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int lat, viol, bviol, prev, a, last, cnt;

    vecs = '{'{3, 45, 45}, '{3, 255, 180}, '{3, 181, 180},
             '{3, 180, 180}, '{3, 0, 0}, '{0, 90, 90}};

    // Reset state
    cyc(3);
    check("reset_angle", int'(angle), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(tgt_ready), 0);
    rst = 1'b0;
    cyc(1);
    check("ready_after_reset", int'(tgt_ready), 1);
    cyc(5);

    // Two-cycle glitch on the switches must never commit
    sw = 4'b1100; sw_ch = 2'd0;
    cyc(2);
    sw = 4'b0000;
    viol = 0;
    repeat (20) begin
      cyc(1);
      if (angle != '0 || busy != '0) viol++;
    end
    check("glitch_no_commit", viol, 0);

    // Held 4'b1111 on channel 2: 2 sync flops, 3 stable cycles, commit edge
    sw = 4'b1111; sw_ch = 2'd2;
    sb_push(2, 180);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      if (busy[2]) begin lat = k; break; end
    end
    check("commit_latency", lat, 6);
`ifdef ANGLE_RAMP_EN
    prev = ang(2); last = -1; cnt = 0; viol = 0; bviol = 0;
    for (int k = 0; k < 1000 && busy[2]; k++) begin
      cyc(1);
      cnt++;
      a = ang(2);
      if (a != prev) begin
        if (a != prev + 1) viol++;
        if (last >= 0 && cnt - last != 4) viol++;
        last = cnt;
        prev = a;
      end
      if (a != 180 && !busy[2]) bviol++;
    end
    check("ramp2_step_cadence", viol, 0);
    check("ramp2_busy_while_moving", bviol, 0);
`endif
    wait_idle(2);
    sb_check("switch_max_ch2");

    // Host write and switch commit to the same channel in one cycle
    sw = 4'b0000; sw_ch = 2'd3;
    cyc(10);
    sw = 4'b1111; sw_ch = 2'd0;
    cyc(lat - 1);
    host_write(0, 50);
    sb_push(0, 50);
    wait_idle(0);
    sb_check("host_wins_same_ch");

    // Host write and switch commit to different channels in one cycle
    sw = 4'b0000; sw_ch = 2'd1;
    cyc(10);
    sw = 4'b1111; sw_ch = 2'd3;
    cyc(lat - 1);
    host_write(0, 60);
    sb_push(0, 60);
    sb_push(3, 180);
    wait_idle(0);
    wait_idle(3);
    sb_check("both_apply_host_ch0");
    sb_check("both_apply_switch_ch3");

    // Clamped write, then retarget mid-ramp
`ifdef ANGLE_RAMP_EN
    host_write(1, 200);
    for (int k = 0; k < 400 && ang(1) != 20; k++) cyc(1);
    check("ch1_reach20", ang(1), 20);
    host_write(1, 10);
    sb_push(1, 10);
    prev = 20; viol = 0;
    for (int k = 0; k < 1000 && busy[1]; k++) begin
      cyc(1);
      a = ang(1);
      if (a != prev) begin
        if (a != prev - 1) viol++;
        prev = a;
      end
    end
    check("ch1_down_steps", viol, 0);
    wait_idle(1);
    sb_check("ch1_retarget_final");
`else
    host_write(1, 200);
    sb_push(1, 180);
    wait_idle(1);
    sb_check("ch1_clamp");
    host_write(1, 10);
    sb_push(1, 10);
    wait_idle(1);
    sb_check("ch1_retarget_final");
`endif

    // Table of host writes
    for (int i = 0; i < 6; i++) begin
      host_write(vecs[i].ch, vecs[i].val);
      sb_push(vecs[i].ch, vecs[i].exp);
      wait_idle(vecs[i].ch);
      sb_check($sformatf("vec%0d", i));
    end
    check("ch2_undisturbed", ang(2), 180);

`ifndef ANGLE_RAMP_EN
    // Without ramping, angle follows one clock after the target write
    host_write(0, 120);
    check("direct_busy_pulse", int'(busy[0]), 1);
    check("direct_angle_before", ang(0), 90);
    cyc(1);
    check("direct_angle_after", ang(0), 120);
    check("direct_busy_clear", int'(busy[0]), 0);
`endif

    // Asynchronous reset while channel 2 sits at 37
`ifdef ANGLE_RAMP_EN
    host_write(2, 0);
    for (int k = 0; k < 1000 && ang(2) != 37; k++) cyc(1);
`else
    host_write(2, 37);
    cyc(1);
`endif
    check("ch2_at37", ang(2), 37);
    #1 rst = 1'b1;
    #1;
    check("async_rst_angle2", ang(2), 0);
    check("async_rst_angles", int'(angle), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(tgt_ready), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    check("ready_after_rerelease", int'(tgt_ready), 1);
    check("angles_after_rerelease", int'(angle), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/servo_angle_ramp.md
SERVO_ANGLE_RAMP -- requirements
Module: servo_angle_ramp

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of servo channels (1..16).
REQ-002 SHALL have parameter ANGLE_W, default 8, bits per angle.
REQ-003 SHALL have parameter MAX_ANGLE, default 180, maximum legal angle.
REQ-004 SHALL have parameter STEP, default 1, angle change per ramp tick.
REQ-005 SHALL have parameter TICK_DIV, default 50000, clock cycles per ramp tick (>=1).
REQ-006 SHALL have parameter DB_CYCLES, default 1000, switch stable-time in cycles (>=1).
REQ-007 clk  input  1  sole clock, rising edge; one clock, all state in this domain.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 sw  input  4  raw switch code {SW1,SW2,SW3,SW4}, asynchronous.
REQ-010 sw_ch  input  clog2(N_CH)  channel the switch code applies to.
REQ-011 tgt_valid  input  1  host target-write request.
REQ-012 tgt_ready  output  1  host write acceptance.
REQ-013 tgt_ch  input  clog2(N_CH)  host write channel.
REQ-014 tgt_angle  input  ANGLE_W  host write target angle.
REQ-015 angle  output  N_CH*ANGLE_W  current angle per channel; channel i at bits [i*ANGLE_W +: ANGLE_W].
REQ-016 busy  output  N_CH  bit i high while angle i != target i.

Function
REQ-017 sw SHALL pass through a 2-flop synchroniser before any use.
REQ-018 Debounce: synchronised code SHALL be accepted as stable only after DB_CYCLES consecutive cycles unchanged; any change restarts the count.
REQ-019 On acceptance of a new stable code differing from the previous stable code, a one-cycle commit SHALL set target[sw_ch] (sw_ch sampled that cycle): 4'b0000->0, 4'b1111->MAX_ANGLE, 4'b1100->MAX_ANGLE/2 (truncated); any other code SHALL leave targets unchanged.
REQ-020 Host write SHALL occur on a clock edge with tgt_valid && tgt_ready; tgt_ready SHALL be 1 in every cycle out of reset.
REQ-021 Host write SHALL set target[tgt_ch] = min(tgt_angle, MAX_ANGLE); a write with tgt_ch >= N_CH SHALL be accepted and discarded.
REQ-022 Host write and switch commit to the same channel in the same cycle: host value SHALL win; to different channels: both SHALL apply.
REQ-023 Tick counter SHALL count 0..TICK_DIV-1 and wrap; ramp tick SHALL be the cycle the counter equals TICK_DIV-1.
REQ-024 On each ramp tick, per channel: angle<target -> angle=min(angle+STEP,target); angle>target -> angle=max(angle-STEP,target); equal -> hold; arithmetic SHALL be ANGLE_W+1 bits wide, no wrap-around.
REQ-025 A target change mid-ramp SHALL take effect at the next tick, ramping from the current angle without reset of the tick counter.
REQ-026 busy SHALL be combinational from registered angle and target.

Reset
REQ-027 On rst: all angles 0, all targets 0, busy 0, tgt_ready 0, tick counter 0, synchroniser, debounce candidate and stable code 4'b0000, debounce count 0.
REQ-028 Reset asserted mid-ramp SHALL immediately force all angles to 0; no commit SHALL fire in the first cycles after release when sw is 4'b0000.

Configuration
REQ-029 Macro ANGLE_RAMP_EN defined: ramp behaviour per REQ-023..REQ-025.
REQ-030 ANGLE_RAMP_EN undefined: tick counter omitted; angle[i] SHALL equal target[i] one clock after any target update; busy high for that one cycle only.

Verification (bench: N_CH=4, TICK_DIV=4, DB_CYCLES=3, STEP=1, MAX_ANGLE=180)
REQ-031 Reset release, sw=4'b1111, sw_ch=2 held 10 cycles -> target2=180, angle2 rises by 1 every 4 cycles, busy[2]=1 until angle2=180.
REQ-032 sw glitches 4'b1100 for 2 cycles then back to 4'b0000 -> no target change, all angles stay 0.
REQ-033 Host write ch1 angle 200 -> target1=180; then at angle1=20 write ch1 angle 10 -> angle1 ramps down 19,18..10 then busy[1]=0.
REQ-034 Same-cycle host write ch0=50 and switch commit ch0 code 4'b1111 -> target0=50; with commit to ch3 instead -> target0=50, target3=180.
REQ-035 Assert rst while angle2=37 ramping -> angle2=0 asynchronously, busy=0, tgt_ready=0.
REQ-036 ANGLE_RAMP_EN undefined, host write ch0=90 -> angle0=90 one cycle later.
